// File: rtl/commit_trace_buffer.sv
// Observer FIFO for the MEM/WB commit trace: captures retired instructions, drops bubbles,
// tags each entry with a sequence number and drains it over a first-word-fall-through read port.
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic                     clr_i,
  input  logic [XLEN-1:0]          pc_i,
  input  logic [XLEN-1:0]          instr_i,
  input  logic [4:0]               reg_addr_i,
  input  logic [XLEN-1:0]          reg_data_i,
  input  logic [XLEN-1:0]          mem_addr_i,
  input  logic [XLEN-1:0]          mem_data_i,
  input  logic                     stall_i,
  input  logic                     flushD_i,
  input  logic                     flushE_i,
  output logic                     rd_valid_o,
  input  logic                     rd_ready_i,
  output logic [XLEN-1:0]          rd_pc_o,
  output logic [XLEN-1:0]          rd_instr_o,
  output logic [XLEN-1:0]          rd_reg_data_o,
  output logic [XLEN-1:0]          rd_mem_addr_o,
  output logic [XLEN-1:0]          rd_mem_data_o,
  output logic [4:0]               rd_reg_addr_o,
  output logic [31:0]              rd_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [15:0]              drop_cnt_o,
  output logic [31:0]              retired_cnt_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic [4:0]      reg_addr;
    logic [XLEN-1:0] reg_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data;
    logic [31:0]     seq;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [31:0]   seq_q;
  logic          overflow_q;
  logic [15:0]   drop_q;

  logic          ret;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;
  entry_t        wr_entry;
  entry_t        head;

  // Read handshake: an entry transfers on every rising edge where rd_valid_o and rd_ready_i
  // are both high; while rd_valid_o is high and rd_ready_i low the head fields do not change.
  // The trace side has no handshake: a retire with no room (and no pop) is dropped.
  always_comb begin
    ret   = en_i & ~stall_i & ~flushD_i & ~flushE_i;
    empty = (wr_ptr == rd_ptr);
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop   = ~empty & rd_ready_i;
    push  = ret & (~full | pop);
    drop  = ret & full & ~pop;

    wr_entry          = '0;
    wr_entry.pc       = pc_i;
    wr_entry.instr    = instr_i;
    wr_entry.reg_addr = reg_addr_i;
    wr_entry.reg_data = reg_data_i;
    wr_entry.mem_addr = mem_addr_i;
    wr_entry.mem_data = mem_data_i;
    wr_entry.seq      = seq_q;
  end

  // Storage is cleared too so that no stale entry can appear on the read port after reset/clear.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      seq_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wr_entry;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (ret) seq_q <= seq_q + 32'd1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign rd_valid_o    = ~empty;
  assign rd_pc_o       = head.pc;
  assign rd_instr_o    = head.instr;
  assign rd_reg_addr_o = head.reg_addr;
  assign rd_reg_data_o = head.reg_data;
  assign rd_mem_addr_o = head.mem_addr;
  assign rd_mem_data_o = head.mem_data;
  assign rd_seq_o      = head.seq;
  assign count_o       = wr_ptr - rd_ptr;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_q;
  // The sequence counter and the retired count advance on exactly the same events.
  assign retired_cnt_o = seq_q;

endmodule
